chord_song_sequencer: RTL and testbench

//  Parametrised successor to the 4-voice song reader. Walks a song ROM and gathers up to NUM_VOICES

---
 rtl/chord_seq_pkg.sv | 28 ++
 rtl/chord_slot_bank.sv | 43 ++++
 rtl/chord_song_sequencer.sv | 162 ++++++++++++++++
 tb/tb_chord_song_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chord_seq_pkg.sv
// rtl/chord_seq_pkg.sv - shared state encoding and ROM word field offsets for the chord sequencer
package chord_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // ROM word layout, MSB first: {chain, note, dur, meta}
    localparam int META_LSB = 0;

    function automatic int dur_lsb(input int meta_w);
        return meta_w;
    endfunction

    function automatic int note_lsb(input int meta_w, input int dur_w);
        return meta_w + dur_w;
    endfunction

    function automatic int chain_bit(input int meta_w, input int dur_w, input int note_w);
        return meta_w + dur_w + note_w;
    endfunction

endpackage

// File: rtl/chord_slot_bank.sv
// rtl/chord_slot_bank.sv - per-voice note/meta registers with indexed write and bulk clear
module chord_slot_bank #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 6,
    parameter int META_W     = 3,
    parameter int IDX_W      = 3
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_wr_en,
    input  logic [IDX_W-1:0]               i_wr_idx,
    input  logic                           i_clear,
    input  logic [NOTE_W-1:0]              i_note,
    input  logic [META_W-1:0]              i_meta,
    output logic [NUM_VOICES*NOTE_W-1:0]   o_notes,
    output logic [NUM_VOICES*META_W-1:0]   o_metas
);

    logic [NUM_VOICES-1:0][NOTE_W-1:0] r_notes;
    logic [NUM_VOICES-1:0][META_W-1:0] r_metas;

    // A clear wipes every slot except the one being written in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_notes <= '0;
            r_metas <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                    r_notes[i] <= i_note;
                    r_metas[i] <= i_meta;
                end else if (i_clear) begin
                    r_notes[i] <= '0;
                    r_metas[i] <= '0;
                end
            end
        end
    end

    assign o_notes = r_notes;
    assign o_metas = r_metas;

endmodule

// File: rtl/chord_song_sequencer.sv
// rtl/chord_song_sequencer.sv - walks a song ROM, gathers chained notes into chords for the note player
module chord_song_sequencer
    import chord_seq_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int META_W     = 3,
    parameter int ADDR_W     = 7,
    parameter int SONG_W     = 2
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_play,
    input  logic                               i_loop,
    input  logic [SONG_W-1:0]                  i_song,
    input  logic                               i_note_done,
    output logic [SONG_W+ADDR_W-1:0]           o_rom_addr,
    input  logic [NOTE_W+DUR_W+META_W:0]       i_rom_data,
    output logic [NUM_VOICES*NOTE_W-1:0]       o_notes,
    output logic [NUM_VOICES*META_W-1:0]       o_metas,
    output logic [DUR_W-1:0]                   o_duration,
    output logic [$clog2(NUM_VOICES+1)-1:0]    o_num_notes,
    output logic                               o_new_note,
    output logic                               o_song_done
);

    localparam int NUM_W     = $clog2(NUM_VOICES + 1);
    localparam int DUR_LSB   = dur_lsb(META_W);
    localparam int NOTE_LSB  = note_lsb(META_W, DUR_W);
    localparam int CHAIN_BIT = chain_bit(META_W, DUR_W, NOTE_W);
    localparam logic [NUM_W-1:0] K_LAST = NUM_W'(NUM_VOICES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [SONG_W-1:0]   r_song_q;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [ADDR_W-1:0]   r_chord_base;
    logic [NUM_W-1:0]    r_k;
    logic                r_wrapped;
    logic [DUR_W-1:0]    r_dur;
    logic [NUM_W-1:0]    r_num_notes;

    logic                w_chain;
    logic [NOTE_W-1:0]   w_note;
    logic [DUR_W-1:0]    w_dur;
    logic [META_W-1:0]   w_meta;
    logic                w_end;
    logic                w_more;
    logic                w_slot_we;
    logic                w_slot_clr;

    assign w_chain = i_rom_data[CHAIN_BIT];
    assign w_note  = i_rom_data[NOTE_LSB +: NOTE_W];
    assign w_dur   = i_rom_data[DUR_LSB +: DUR_W];
    assign w_meta  = i_rom_data[META_LSB +: META_W];

    // A wrap of the address during the previous chord counts as the end marker
    assign w_end  = (r_k == '0) && ((w_dur == '0) || r_wrapped);
    assign w_more = w_chain && (r_k != K_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (i_play) w_next_state = ST_FETCH;
            ST_FETCH:   w_next_state = i_play ? ST_CAPTURE : ST_IDLE;
            ST_CAPTURE: begin
                if (!i_play)     w_next_state = ST_IDLE;
                else if (w_end)  w_next_state = i_loop ? ST_FETCH : ST_DONE;
                else if (w_more) w_next_state = ST_FETCH;
                else             w_next_state = ST_ISSUE;
            end
            ST_ISSUE:   w_next_state = ST_HOLD;
            ST_HOLD:    if (i_note_done) w_next_state = i_play ? ST_FETCH : ST_IDLE;
            ST_DONE:    if (!i_play) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_new_note  = (r_state == ST_ISSUE);
        o_song_done = (r_state == ST_CAPTURE) && i_play && w_end && !i_loop;
        w_slot_we   = (r_state == ST_CAPTURE) && i_play && !w_end;
        w_slot_clr  = w_slot_we && (r_k == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_song_q     <= '0;
            r_addr_q     <= '0;
            r_chord_base <= '0;
            r_k          <= '0;
            r_wrapped    <= 1'b0;
            r_dur        <= '0;
            r_num_notes  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_song_q <= i_song;
                    r_k      <= '0;
                    if (i_song != r_song_q) begin
                        r_addr_q  <= '0;
                        r_wrapped <= 1'b0;
                    end
                end
                ST_FETCH, ST_CAPTURE: begin
                    if (!i_play) begin
                        // Pause: rewind so the whole chord is replayed on resume
                        r_k <= '0;
                        if (r_k != '0) begin
                            r_addr_q  <= r_chord_base;
                            r_wrapped <= 1'b0;
                        end
                    end else if (r_state == ST_CAPTURE) begin
                        if (w_end) begin
                            r_addr_q  <= '0;
                            r_wrapped <= 1'b0;
                        end else begin
                            r_addr_q <= r_addr_q + ADDR_W'(1);
                            if (r_addr_q == '1) r_wrapped <= 1'b1;
                            if (r_k == '0) begin
                                r_chord_base <= r_addr_q;
                                r_dur        <= w_dur;
                            end
                            if (w_more) r_k         <= r_k + NUM_W'(1);
                            else        r_num_notes <= r_k + NUM_W'(1);
                        end
                    end
                end
                ST_HOLD: if (i_note_done) r_k <= '0;
                default: ;
            endcase
        end
    end

    chord_slot_bank #(
        .NUM_VOICES (NUM_VOICES),
        .NOTE_W     (NOTE_W),
        .META_W     (META_W),
        .IDX_W      (NUM_W)
    ) u_slots (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wr_en  (w_slot_we),
        .i_wr_idx (r_k),
        .i_clear  (w_slot_clr),
        .i_note   (w_note),
        .i_meta   (w_meta),
        .o_notes  (o_notes),
        .o_metas  (o_metas)
    );

    assign o_rom_addr  = {r_song_q, r_addr_q};
    assign o_duration  = r_dur;
    assign o_num_notes = r_num_notes;

endmodule

// File: tb/tb_chord_song_sequencer.sv
// tb/tb_chord_song_sequencer.sv - scoreboard bench for chord_song_sequencer
module tb_chord_song_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        loop = 1'b0;
    logic        note_done = 1'b0;
    logic [1:0]  song = 2'd0;
    logic [8:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [23:0] notes;
    logic [11:0] metas;
    logic [5:0]  duration;
    logic [2:0]  num_notes;
    logic        new_note;
    logic        song_done;

    logic [15:0] rom [0:511];

    typedef struct {
        bit          is_done;
        logic [23:0] notes;
        logic [11:0] metas;
        logic [5:0]  dur;
        logic [2:0]  num;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    chord_song_sequencer dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_play      (play),
        .i_loop      (loop),
        .i_song      (song),
        .i_note_done (note_done),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_notes     (notes),
        .o_metas     (metas),
        .o_duration  (duration),
        .o_num_notes (num_notes),
        .o_new_note  (new_note),
        .o_song_done (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [15:0] w(input int ch, input int nt, input int du, input int mt);
        return {ch[0], nt[5:0], du[5:0], mt[2:0]};
    endfunction

    function automatic exp_t mk(input int num, input int dur, input logic [23:0] n, input logic [11:0] m);
        exp_t e;
        e.is_done = 1'b0;
        e.notes   = n;
        e.metas   = m;
        e.dur     = dur[5:0];
        e.num     = num[2:0];
        return e;
    endfunction

    function automatic exp_t mk_done();
        exp_t e;
        e.is_done = 1'b1;
        e.notes   = '0;
        e.metas   = '0;
        e.dur     = '0;
        e.num     = '0;
        return e;
    endfunction

    // Monitor: every chord or end-of-song pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (new_note || song_done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: new_note=%0b song_done=%0b, none expected", new_note, song_done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_done) begin
                    if (!(song_done && !new_note)) begin
                        errors++;
                        $display("FAIL song_done_event: new_note=%0b song_done=%0b, required song_done=1 new_note=0",
                                 new_note, song_done);
                    end
                end else if (!(new_note && !song_done) || notes !== e.notes || metas !== e.metas ||
                             duration !== e.dur || num_notes !== e.num) begin
                    errors++;
                    $display("FAIL chord: nn=%0b sd=%0b notes=%h metas=%h dur=%0d num=%0d, required notes=%h metas=%h dur=%0d num=%0d",
                             new_note, song_done, notes, metas, duration, num_notes, e.notes, e.metas, e.dur, e.num);
                end
            end
        end
    end

    // Note player: acknowledges each chord a few cycles after it is issued
    initial begin
        forever begin
            @(negedge clk);
            if (new_note) begin
                repeat (4) @(negedge clk);
                note_done = 1'b1;
                @(negedge clk);
                note_done = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_sb(input string name, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected outputs still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic measure(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!new_note && n < 40);
        check(name, n, 5);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    exp_t ch1, ch2, ch3;

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = '0;
        rom[0] = w(1, 5, 10, 1);
        rom[1] = w(0, 7, 3, 2);
        rom[2] = w(1, 10, 20, 4);
        rom[3] = w(1, 11, 9, 5);
        rom[4] = w(1, 12, 9, 6);
        rom[5] = w(1, 13, 9, 7);
        rom[6] = w(0, 14, 6, 3);
        for (int i = 0; i < 128; i++) rom[256 + i] = w((i % 4 != 3) ? 1 : 0, i % 64, (i % 63) + 1, i % 8);

        ch1 = mk(2, 10, {6'd0, 6'd0, 6'd7, 6'd5}, {3'd0, 3'd0, 3'd2, 3'd1});
        ch2 = mk(4, 20, {6'd13, 6'd12, 6'd11, 6'd10}, {3'd7, 3'd6, 3'd5, 3'd4});
        ch3 = mk(1, 6, {18'd0, 6'd14}, {9'd0, 3'd3});

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(|{rom_addr, notes, metas, duration, num_notes, new_note, song_done}), 0);
        reset = 1'b0;

        // Song 0 to its end marker, no loop
        sb.push_back(ch1);
        sb.push_back(ch2);
        sb.push_back(ch3);
        sb.push_back(mk_done());
        @(posedge clk);
        #1 play = 1'b1;
        measure("latency_2note");
        wait_sb("song0_run", 300);
        repeat (10) @(negedge clk);
        check("done_addr", 32'(rom_addr), 0);
        play = 1'b0;
        repeat (3) @(posedge clk);

        // Loop mode replays word 0 without a song_done pulse
        loop = 1'b1;
        sb.push_back(ch1);
        sb.push_back(ch2);
        sb.push_back(ch3);
        sb.push_back(ch1);
        @(posedge clk);
        #1 play = 1'b1;
        wait_sb("loop_run", 300);
        play = 1'b0;
        loop = 1'b0;
        repeat (10) @(posedge clk);

        // Pause in the capture of the second chord note
        do_reset();
        sb.push_back(ch1);
        @(posedge clk);
        #1 play = 1'b1;
        repeat (4) @(posedge clk);
        #1 play = 1'b0;
        @(posedge clk);
        #1;
        check("pause_rewind_addr", 32'(rom_addr), 0);
        play = 1'b1;
        measure("latency_resume");
        play = 1'b0;
        wait_sb("pause_run", 50);
        repeat (10) @(posedge clk);

        // Song select in IDLE, then song 2 runs through an address wrap
        song = 2'd2;
        @(posedge clk);
        #1;
        check("song_select_addr", 32'(rom_addr), 32'h100);
        for (int j = 0; j < 32; j++) begin
            logic [23:0] n;
            logic [11:0] m;
            int idx;
            n = '0;
            m = '0;
            for (int s = 0; s < 4; s++) begin
                idx = 4 * j + s;
                n[s*6 +: 6] = idx[5:0];
                m[s*3 +: 3] = idx[2:0];
            end
            sb.push_back(mk(4, ((4 * j) % 63) + 1, n, m));
        end
        sb.push_back(mk_done());
        play = 1'b1;
        wait_sb("song2_wrap", 2000);
        repeat (5) @(negedge clk);
        check("song2_done_addr", 32'(rom_addr), 32'h100);
        play = 1'b0;
        repeat (3) @(posedge clk);

        // Reset while holding a chord
        song = 2'd0;
        sb.push_back(ch1);
        @(posedge clk);
        #1 play = 1'b1;
        begin
            int n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!new_note && n < 40);
            check("hold_reached", 32'(new_note), 1);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_hold", 32'(|{rom_addr, notes, metas, duration, num_notes, new_note, song_done}), 0);
        reset = 1'b0;
        play = 1'b0;
        repeat (10) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
